// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC sequencer slice.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 32;

    // Output clamp limits for the default sample width.
    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX_DEF = 16'sh7FFF;
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN_DEF = 16'sh8000;

endpackage

// File: rtl/fir_history_ram.sv
// Circular sample history: register array, one write port, combinational read, sync clear.
module fir_history_ram #(
    parameter int unsigned N_TAPS = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(N_TAPS)-1:0] waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [$clog2(N_TAPS)-1:0] raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem_q [N_TAPS];
    logic [DATA_W-1:0] mem_d [N_TAPS];

    // Next-state of the array: single-entry write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/multaddsub.sv
// Shared combinational multiply-add/subtract core: c = din +/- a*b (signed).
module multaddsub #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ACC_WIDTH-1:0]  din,
    input  logic                  sub,
    output logic [ACC_WIDTH-1:0]  c
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    // Signed product, sign-extended to the accumulator width, then added or subtracted.
    always_comb begin
        prod     = $signed(a) * $signed(b);
        prod_ext = ACC_WIDTH'(prod);
        c        = sub ? (din - prod_ext) : (din + prod_ext);
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: accepts a sample, runs N_TAPS MACs on the shared core,
// then presents a rounded, saturated result on a valid/ready output.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned N_TAPS    = 16,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [DATA_W-1:0]         coef_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      busy
);

    localparam int unsigned AW = $clog2(N_TAPS);
    localparam int unsigned RW = ACC_W + 1;
    localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);
    localparam logic signed [RW-1:0] RND_BIAS = RW'(1) << (OUT_SHIFT - 1);
    localparam logic signed [RW-1:0] SAT_HI   = (RW'(1) << (DATA_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_LO   = ~SAT_HI;

    fir_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] coef_q [N_TAPS];
    logic [DATA_W-1:0] coef_d [N_TAPS];

    logic              hist_we;
    logic [AW-1:0]     hist_raddr;
    logic [DATA_W-1:0] hist_rdata;
    logic [ACC_W-1:0]  mac_c;

    logic signed [RW-1:0] acc_ext;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] rnd;
    logic [DATA_W-1:0]    sat_out;

    assign hist_raddr = wr_ptr_q - k_q;

    fir_history_ram #(
        .N_TAPS (N_TAPS),
        .DATA_W (DATA_W)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .we    (hist_we),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (hist_raddr),
        .rdata (hist_rdata)
    );

    multaddsub #(
        .DATA_WIDTH (DATA_W),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .a   (coef_q[k_q]),
        .b   (hist_rdata),
        .din (acc_q),
        .sub (1'b0),
        .c   (mac_c)
    );

    // Round half up at ACC_W+1 bits from the final MAC result, then clamp to DATA_W.
    always_comb begin
        acc_ext = RW'($signed(mac_c));
        rnd_sum = acc_ext + RND_BIAS;
        rnd     = rnd_sum >>> OUT_SHIFT;
        if (rnd > SAT_HI) begin
            sat_out = SAT_HI[DATA_W-1:0];
        end else if (rnd < SAT_LO) begin
            sat_out = SAT_LO[DATA_W-1:0];
        end else begin
            sat_out = rnd[DATA_W-1:0];
        end
    end

    // Control FSM next-state: accept, step the MAC through every tap, hold the result.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        k_d       = k_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        coef_d    = coef_q;
        hist_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (coef_we) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (s_valid) begin
                    hist_we = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = mac_c;
                k_d   = k_q + AW'(1);
                if (k_q == K_LAST) begin
                    m_valid_d = 1'b1;
                    m_data_d  = sat_out;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Register all state; reset discards any in-flight sample and clears the coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            coef_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
            coef_q    <= coef_d;
        end
    end

    // Ready is withheld while reset is asserted so nothing is accepted during reset.
    assign s_ready = (state_q == ST_IDLE) && !rst;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a dot-product reference model.
module tb_fir_mac_sequencer;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic signed [15:0] m_coef [N];
    logic signed [15:0] m_hist [N];
    int                 m_wp;

    always #5 clk = ~clk;

    fir_mac_sequencer #(
        .N_TAPS    (16),
        .DATA_W    (16),
        .ACC_W     (32),
        .OUT_SHIFT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out();
        int     acc;
        longint r;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += int'(m_coef[k]) * int'(m_hist[(m_wp - k) & (N - 1)]);
        end
        r = (longint'(acc) + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_coef[i] = '0;
            m_hist[i] = '0;
        end
        m_wp = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; coef_we = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sready", {31'd0, s_ready}, 32'd0);
        check("rst_mvalid", {31'd0, m_valid}, 32'd0);
        check("rst_mdata",  {16'd0, m_data},  32'd0);
        check("rst_busy",   {31'd0, busy},    32'd0);
        rst = 1'b0;
        #1;
        check("rst_sready_after", {31'd0, s_ready}, 32'd1);
        model_clear();
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input logic [15:0] val);
        coef_we = 1'b1; coef_addr = addr[3:0]; coef_data = val;
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[addr] = val;
    endtask

    // One transaction; optional backpressure and an attempted coefficient write while busy.
    task automatic send(input logic [15:0] x, input int hold, input bit busy_wr, output logic [15:0] got);
        int          n;
        logic [15:0] exp;
        logic [15:0] held;
        n = 0;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        if (!s_ready) check("sready_timeout", 32'd0, 32'd1);
        s_valid = 1'b1; s_data = x; m_ready = (hold == 0);
        @(negedge clk);
        s_valid = 1'b0; s_data = '0;
        m_hist[m_wp] = x;
        exp = model_out();
        check("mac_busy",   {31'd0, busy},    32'd1);
        check("mac_sready", {31'd0, s_ready}, 32'd0);
        n = 1;
        while (!m_valid && n < 40) begin
            if (busy_wr && n == 3) begin
                coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'h1234;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        coef_we = 1'b0;
        check("latency", n, 32'd17);
        check("mdata", {16'd0, m_data}, {16'd0, exp});
        held = m_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_mvalid", {31'd0, m_valid}, 32'd1);
            check("bp_mdata",  {16'd0, m_data},  {16'd0, held});
            check("bp_sready", {31'd0, s_ready}, 32'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_wp = (m_wp + 1) & (N - 1);
        check("post_mvalid", {31'd0, m_valid}, 32'd0);
        check("post_sready", {31'd0, s_ready}, 32'd1);
        got = held;
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] rv;
        int          n;
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Impulse response
        for (int k = 0; k < N; k++) write_coef(k, 16'(k * 256));
        for (int k = 0; k < N; k++) begin
            send((k == 0) ? 16'h4000 : 16'h0000, 0, 1'b0, got);
            check("impulse", {16'd0, got}, 32'(k * 128));
        end

        // Positive saturation
        do_reset();
        write_coef(0, 16'h7FFF); write_coef(1, 16'h7FFF);
        send(16'h7FFF, 0, 1'b0, got);
        send(16'h7FFF, 0, 1'b0, got);
        check("sat_pos", {16'd0, got}, 32'h7FFF);

        // Negative saturation
        do_reset();
        write_coef(0, 16'h8000); write_coef(1, 16'h8000);
        send(16'h7FFF, 0, 1'b0, got);
        check("neg_single", {16'd0, got}, 32'h8001);
        send(16'h7FFF, 0, 1'b0, got);
        check("sat_neg", {16'd0, got}, 32'h8000);

        // Backpressure
        send(16'h0100, 5, 1'b0, got);

        // Reset mid-MAC
        s_valid = 1'b1; s_data = 16'h7000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_mvalid", {31'd0, m_valid}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("midrst_sready", {31'd0, s_ready}, 32'd1);
        model_clear();
        n = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (m_valid) n++;
        end
        check("midrst_no_out", n, 32'd0);
        write_coef(0, 16'h4000);
        send(16'h4000, 0, 1'b0, got);
        check("midrst_imp", {16'd0, got}, 32'h2000);

        // Coefficient write while busy is dropped; the same write in IDLE lands
        send(16'h4000, 0, 1'b1, got);
        write_coef(0, 16'h1234);
        send(16'h0000, 0, 1'b0, got);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 20; i++) begin
            if ((i % 7) == 3) write_coef($urandom_range(0, N - 1), 16'($urandom_range(0, 16'hFFFF)));
            rv = 16'($urandom_range(0, 16'hFFFF));
            send(rv, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR filter controller built around the shared combinational `multaddsub` multiply-add core. It accepts one 16-bit sample per valid/ready handshake and stores it in a circular history buffer. It then steps the single MAC through all N_TAPS coefficient/sample products, one per cycle, and emits a rounded, saturated 16-bit result on an output valid/ready port. It sits between the audio sample source and downstream output logic; it is the only owner of the MAC core.

## Interface
- N_TAPS, 16, number of taps; power of two, ≥2
- DATA_W, 16, sample and coefficient width (signed)
- ACC_W, 32, accumulator width (signed); passed to `multaddsub` ACC_WIDTH
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output (Q15 coefficients)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(N_TAPS)  coefficient index
- coef_data  in  DATA_W  signed coefficient
- s_valid  in  1  input sample valid
- s_ready  out  1  sequencer can accept a sample
- s_data  in  DATA_W  signed input sample
- m_valid  out  1  output result valid
- m_ready  in  1  downstream accepts result
- m_data  out  DATA_W  signed filtered output
- busy  out  1  high in MAC or OUT state

## Operation
- States: IDLE, MAC, OUT.
- IDLE: s_ready=1. On s_valid&&s_ready:
  - write s_data to hist[wr_ptr]
  - clear acc to 0, set k=0
  - go to MAC
- MAC: drive `multaddsub` with a=coef[k], b=hist[(wr_ptr−k) mod N_TAPS], din=acc. Register acc<=c. Increment k.
  - After the k=N_TAPS−1 product is registered, go to OUT.
  - The sample just written is used at k=0.
- Output formation (registered on MAC→OUT):
  - r = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, computed at ACC_W+1 bits (round half up)
  - clamp r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]
- OUT: m_valid=1, m_data held stable. On m_ready: wr_ptr<=wr_ptr+1 (mod N_TAPS), then go to IDLE.
- acc wraps in two's complement at ACC_W bits. Coefficient sets must keep the sum in range. Saturation applies only at the output.
- Coefficient writes are accepted only when busy=0. coef_we while busy=1 is ignored (dropped, not queued).
- History wrap: wr_ptr and the read index wrap modulo N_TAPS with no bubble.

## Timing
- Reset (any state, including mid-MAC): state=IDLE, in-flight sample discarded, no output produced. Reset values:
  - s_ready=0 while rst is high, 1 the first cycle after
  - m_valid=0, m_data=0, busy=0
  - wr_ptr=0, k=0, acc=0
  - all hist entries and all coef entries = 0
- Handshake accepted at cycle T:
  - MAC occupies T+1..T+N_TAPS
  - m_valid rises at T+N_TAPS+1 (latency N_TAPS+1)
- With m_ready held high: IDLE again at T+N_TAPS+2. Max throughput is one sample per N_TAPS+2 cycles.
- s_ready=0 in MAC and OUT. s_valid is ignored there; the source must hold it.
- m_valid never drops without m_ready. m_data does not change while m_valid=1 and m_ready=0.
- coef_we and s_valid handshake in the same IDLE cycle: both take effect. The write is visible from the first MAC cycle.

## Structure
- Shared package `fir_pkg`:
  - state enum (IDLE, MAC, OUT)
  - DATA_W/ACC_W defaults
  - saturation limit constants
- Sub-module `fir_history_ram`: N_TAPS×DATA_W register array with one write port, one combinational read port, and synchronous clear on rst.
- Coefficient array and control FSM live in the top. `multaddsub` is instantiated once, unmodified.

## Test plan
- Impulse: coef[k]=k·256 for all k. Feed 0x4000 then 15×0 with m_ready=1 → outputs 0,128,256,…,1920 in order. Each m_valid arrives exactly 17 cycles after accept.
- Positive saturation: coef[0]=coef[1]=0x7FFF, others 0. Feed 0x7FFF twice → second output 0x7FFF (unclamped 65532).
- Negative saturation: coef[0]=coef[1]=0x8000. Feed 0x7FFF twice → second output 0x8000. Single product case (first output) = 0x8001.
- Backpressure: hold m_ready=0 for 5 cycles in OUT → m_valid=1 and m_data stable throughout, s_ready=0. Next accept occurs only after the m_ready cycle.
- Reset mid-MAC: assert rst at T+5 → m_valid stays 0, s_ready=1 the cycle after rst drops. A subsequent impulse with coef[0]=0x4000 yields 0x2000 (history cleared).
- Coefficient write while busy: coef_we during MAC → ignored. The following output reflects the old coefficient; the same write in IDLE takes effect.
